// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer blocks: default Q-format
// and layer sizes, the MAC controller state encoding, and the
// shift-and-saturate helper used when an accumulator is turned back into a
// fixed-point value.
package nn_pkg;

    localparam int RESOLUTION = 16;
    localparam int FRAC_BITS  = 8;
    localparam int NUM_INPUT  = 784;
    localparam int NUM_HIDDEN = 30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } mac_state_t;

    // The caller sign-extends its accumulator to 64 bits. The arithmetic shift
    // drops the extra fractional bits, which rounds toward -inf. The result
    // is then clamped to the signed range of a res-bit word. The return value
    // is 32 bits wide, and the caller narrows it to res bits.
    function automatic logic signed [31:0] sat_shift(input logic signed [63:0] acc,
                                                     input int frac,
                                                     input int res);
        logic signed [63:0] shifted;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        shifted = acc >>> frac;
        max_v   = (64'sd1 <<< (res - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (res - 1));
        if (shifted > max_v) begin
            sat_shift = 32'(max_v);
        end else if (shifted < min_v) begin
            sat_shift = 32'(min_v);
        end else begin
            sat_shift = 32'(shifted);
        end
    endfunction

endpackage

// File: rtl/hidden_layer_mac_mac_unit.sv
// One neuron's multiply-accumulate lane. When a new image starts, the
// accumulator is preloaded with the bias. The bias is scaled by 2^frac_bits
// so that it lines up with the full-precision x*w products.
module mac_unit
    import nn_pkg::*;
#(
    parameter int resolution = RESOLUTION,
    parameter int frac_bits  = FRAC_BITS,
    parameter int acc_width  = 2 * RESOLUTION + $clog2(NUM_INPUT)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_bias,
    input  logic signed [resolution-1:0] bias,
    input  logic                        mac_en,
    input  logic signed [resolution-1:0] x,
    input  logic signed [resolution-1:0] w,
    output logic signed [acc_width-1:0]  acc
);

    logic signed [2*resolution-1:0] product;
    logic signed [acc_width-1:0]    bias_ext;
    logic signed [acc_width-1:0]    product_ext;

    assign product     = x * w;
    assign bias_ext    = acc_width'(bias) <<< frac_bits;
    assign product_ext = acc_width'(product);

    // Either preload the bias or add the current product. There is enough
    // headroom in the accumulator that it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load_bias) begin
            acc <= bias_ext;
        end else if (mac_en) begin
            acc <= acc + product_ext;
        end
    end

endmodule

// File: rtl/hidden_layer_mac.sv
// Hidden-layer pre-activation engine. It streams one pixel per handshake and
// fetches the matching weight row from an external ROM with 1-cycle latency.
// All neurons accumulate in parallel. At the end of an image it presents the
// saturated Q-format results to the sigmoid stage.
module hidden_layer_mac
    import nn_pkg::*;
#(
    parameter int resolution    = RESOLUTION,
    parameter int frac_bits     = FRAC_BITS,
    parameter int number_input  = NUM_INPUT,
    parameter int number_neuron = NUM_HIDDEN
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  pixel_valid,
    output logic                                  pixel_ready,
    input  logic [resolution-1:0]                 pixel_data,
    output logic [$clog2(number_input)-1:0]       weight_addr,
    input  logic [number_neuron*resolution-1:0]   weight_data,
    input  logic [number_neuron*resolution-1:0]   bias_data,
    output logic [number_neuron*resolution-1:0]   zeds,
    output logic                                  zeds_valid,
    input  logic                                  zeds_ready,
    output logic                                  busy
);

    localparam int AW    = $clog2(number_input);
    localparam int ACC_W = 2 * resolution + $clog2(number_input);
    localparam logic [AW-1:0] LAST_IDX = AW'(number_input - 1);

    mac_state_t state;
    mac_state_t state_next;

    logic [AW-1:0]                  idx;
    logic signed [resolution-1:0]   pixel_q;
    logic                           mac_en;
    logic                           handshake;
    logic                           load_bias;
    logic signed [ACC_W-1:0]        acc_vec [number_neuron];
    logic [number_neuron*resolution-1:0] zeds_next;

    assign pixel_ready = (state == ST_LOAD);
    assign busy        = (state != ST_IDLE);
    assign handshake   = pixel_valid & pixel_ready;
    assign load_bias   = (state == ST_IDLE) & start;
    assign weight_addr = idx;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DRAIN is a single cycle, which gives the last
    // product time to land in the accumulators.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_LOAD;
            ST_LOAD:  if (handshake && (idx == LAST_IDX)) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_OUT;
            ST_OUT:   if (zeds_valid && zeds_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // On each handshake, capture the pixel and set up the MAC for the next
    // cycle. That is the cycle in which the weight row arrives from the ROM.
    // The index saturates at the last pixel so that it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            pixel_q <= '0;
            mac_en  <= 1'b0;
        end else begin
            mac_en <= handshake;
            if (handshake) begin
                pixel_q <= pixel_data;
            end
            if (load_bias) begin
                idx <= '0;
            end else if (handshake && (idx != LAST_IDX)) begin
                idx <= idx + 1'b1;
            end
        end
    end

    genvar j;
    generate
        for (j = 0; j < number_neuron; j++) begin : g_neuron
            mac_unit #(
                .resolution(resolution),
                .frac_bits (frac_bits),
                .acc_width (ACC_W)
            ) u_mac (
                .clk      (clk),
                .rst_n    (rst_n),
                .load_bias(load_bias),
                .bias     (bias_data[j*resolution +: resolution]),
                .mac_en   (mac_en),
                .x        (pixel_q),
                .w        (weight_data[j*resolution +: resolution]),
                .acc      (acc_vec[j])
            );
        end
    endgenerate

    // Convert every accumulator back to the Q format, with saturation.
    always_comb begin
        zeds_next = '0;
        for (int n = 0; n < number_neuron; n++) begin
            zeds_next[n*resolution +: resolution] =
                resolution'(sat_shift(64'(acc_vec[n]), frac_bits, resolution));
        end
    end

    // Output register. It loads once, on the first OUT cycle, and then holds
    // until downstream takes the result. zeds keep their value after that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zeds       <= '0;
            zeds_valid <= 1'b0;
        end else if (state == ST_OUT) begin
            if (!zeds_valid) begin
                zeds       <= zeds_next;
                zeds_valid <= 1'b1;
            end else if (zeds_ready) begin
                zeds_valid <= 1'b0;
            end
        end
    end

endmodule
